// File: rtl/correction_applicator_pkg.sv
//============================================================================
// Module : correction_applicator_pkg
// Brief  : Shared lane layout, width derivation and offset constant for the
//          X-engine correction applicator.
// Rev    : 1.0
//============================================================================
`default_nettype none

package correction_applicator_pkg;

  // Lane order inside the packed words; RE_XX occupies the most significant slot.
  localparam int N_LANES = 8;
  localparam int RE_XX   = 0;
  localparam int RE_XY   = 1;
  localparam int RE_YX   = 2;
  localparam int RE_YY   = 3;
  localparam int IM_XX   = 4;
  localparam int IM_XY   = 5;
  localparam int IM_YX   = 6;
  localparam int IM_YY   = 7;

  function automatic int corr_width(input int serial_acc_len_bits,
                                    input int p_factor_bits,
                                    input int bitwidth);
    return p_factor_bits + serial_acc_len_bits + bitwidth + 3;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return (N_LANES - 1 - lane) * width;
  endfunction

  function automatic bit is_real_lane(input int lane);
    return lane < IM_XX;
  endfunction

  // N*k^2 term left in every real accumulator by the unsigned sample offset.
  function automatic longint unsigned nk2(input int bitwidth,
                                          input int serial_acc_len_bits,
                                          input int p_factor_bits);
    return 64'd1 << (2 * (bitwidth - 1) + serial_acc_len_bits + p_factor_bits);
  endfunction

endpackage

`default_nettype wire

// File: rtl/corr_fifo.sv
//============================================================================
// Module : corr_fifo
// Brief  : First-word fall-through synchronous FIFO with occupancy level and
//          push-to-pop bypass when empty.
// Rev    : 1.0
//============================================================================
`default_nettype none

module corr_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic [DEPTH_BITS:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int                c_depth      = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] c_full_level = (DEPTH_BITS + 1)'(c_depth);

  logic [WIDTH-1:0]      r_mem [c_depth];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_level;
  logic                  w_bypass;
  logic                  w_write;
  logic                  w_read;

  assign empty    = (r_level == '0);
  assign full     = (r_level == c_full_level);
  // Simultaneous push and pop on an empty FIFO hands the word straight through.
  assign w_bypass = empty && push && pop;
  assign w_write  = push && (!full || pop) && !w_bypass;
  assign w_read   = pop && !empty;
  assign pop_data = empty ? push_data : r_mem[r_rd_ptr];
  assign level    = r_level;

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
      end
      if (w_read) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
      end
      case ({w_write, w_read})
        2'b10:   r_level <= r_level + (DEPTH_BITS + 1)'(1);
        2'b01:   r_level <= r_level - (DEPTH_BITS + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/correction_applicator.sv
//============================================================================
// Module : correction_applicator
// Brief  : Pops one buffered per-baseline correction per X-engine output and
//          removes the scaled correction and constant offset term.
// Rev    : 1.0
//============================================================================
`default_nettype none

module correction_applicator
  import correction_applicator_pkg::*;
#(
  parameter int SERIAL_ACC_LEN_BITS = 8,
  parameter int P_FACTOR_BITS       = 0,
  parameter int BITWIDTH            = 4,
  parameter int CORR_WIDTH          = corr_width(SERIAL_ACC_LEN_BITS, P_FACTOR_BITS, BITWIDTH),
  parameter int XENG_WIDTH          = 32,
  parameter int FIFO_DEPTH_BITS     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            corr_vld,
  input  logic [N_LANES*CORR_WIDTH-1:0]   corr_din,
  input  logic                            corr_last,
  input  logic                            corr_buf_sel,
  input  logic                            xeng_sync,
  input  logic                            xeng_vld,
  input  logic [N_LANES*XENG_WIDTH-1:0]   xeng_din,
  output logic [N_LANES*XENG_WIDTH-1:0]   dout,
  output logic                            dout_vld,
  output logic                            dout_last,
  output logic                            dout_buf_sel,
  output logic                            sync_out,
  output logic [FIFO_DEPTH_BITS:0]        fifo_level,
  output logic                            err_overflow,
  output logic                            err_underflow
);

  localparam int                    c_shift   = BITWIDTH - 1;
  localparam int                    c_entry_w = N_LANES * CORR_WIDTH + 2;
  localparam logic [XENG_WIDTH-1:0] c_nk2     =
      XENG_WIDTH'(nk2(BITWIDTH, SERIAL_ACC_LEN_BITS, P_FACTOR_BITS));

  logic [c_entry_w-1:0] w_fifo_data;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_have_corr;

  logic r_s1_vld;
  logic r_s1_off;
  logic r_s1_last;
  logic r_s1_buf_sel;
  logic r_sync_d1;
  logic r_sync_d2;
  logic r_dout_vld;
  logic r_dout_last;
  logic r_dout_buf_sel;
  logic r_err_overflow;
  logic r_err_underflow;

  corr_fifo #(
    .WIDTH      (c_entry_w),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_corr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (corr_vld),
    .push_data ({corr_buf_sel, corr_last, corr_din}),
    .pop       (xeng_vld),
    .pop_data  (w_fifo_data),
    .level     (fifo_level),
    .full      (w_full),
    .empty     (w_empty)
  );

  // A pushed word reaches the pop side in the same cycle when the FIFO is empty.
  assign w_have_corr = !w_empty || corr_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld        <= 1'b0;
      r_s1_off        <= 1'b0;
      r_s1_last       <= 1'b0;
      r_s1_buf_sel    <= 1'b0;
      r_dout_vld      <= 1'b0;
      r_dout_last     <= 1'b0;
      r_dout_buf_sel  <= 1'b0;
      r_sync_d1       <= 1'b0;
      r_sync_d2       <= 1'b0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      r_s1_vld        <= xeng_vld;
      r_s1_off        <= xeng_vld && w_have_corr;
      r_s1_last       <= xeng_vld && w_have_corr && w_fifo_data[c_entry_w-2];
      r_s1_buf_sel    <= xeng_vld && w_have_corr && w_fifo_data[c_entry_w-1];
      r_dout_vld      <= r_s1_vld;
      r_dout_last     <= r_s1_last;
      r_dout_buf_sel  <= r_s1_buf_sel;
      r_sync_d1       <= xeng_sync;
      r_sync_d2       <= r_sync_d1;
      r_err_overflow  <= r_err_overflow  || (corr_vld && w_full && !xeng_vld);
      r_err_underflow <= r_err_underflow || (xeng_vld && w_empty && !corr_vld);
    end
  end

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    localparam int c_clsb    = lane_lsb(gi, CORR_WIDTH);
    localparam int c_xlsb    = lane_lsb(gi, XENG_WIDTH);
    localparam bit c_is_real = is_real_lane(gi);

    logic signed [CORR_WIDTH-1:0] w_corr;
    logic [XENG_WIDTH-1:0]        w_corr_ext;
    logic [XENG_WIDTH-1:0]        r_s1_raw;
    logic [XENG_WIDTH-1:0]        r_s1_corr;
    logic [XENG_WIDTH-1:0]        r_s2;

    assign w_corr     = w_fifo_data[c_clsb +: CORR_WIDTH];
    assign w_corr_ext = XENG_WIDTH'(w_corr);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1_raw  <= '0;
        r_s1_corr <= '0;
        r_s2      <= '0;
      end else begin
        r_s1_raw  <= xeng_din[c_xlsb +: XENG_WIDTH];
        r_s1_corr <= w_have_corr ? (w_corr_ext << c_shift) : '0;
        // Offset only applies alongside a real correction; underflow passes raw data.
        r_s2      <= r_s1_raw - r_s1_corr - ((c_is_real && r_s1_off) ? c_nk2 : '0);
      end
    end

    assign dout[c_xlsb +: XENG_WIDTH] = r_s2;
  end

  assign dout_vld      = r_dout_vld;
  assign dout_last     = r_dout_last;
  assign dout_buf_sel  = r_dout_buf_sel;
  assign sync_out      = r_sync_d2;
  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;

endmodule

`default_nettype wire

// File: tb/tb_correction_applicator.sv
//============================================================================
// Module : tb_correction_applicator
// Brief  : Directed self-checking bench for correction_applicator.
// Rev    : 1.0
//============================================================================
`default_nettype none

module tb_correction_applicator;
  import correction_applicator_pkg::*;

  localparam int CW = 15;
  localparam int XW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              corr_vld;
  logic [8*CW-1:0]   corr_din;
  logic              corr_last;
  logic              corr_buf_sel;
  logic              xeng_sync;
  logic              xeng_vld;
  logic [8*XW-1:0]   xeng_din;
  logic [8*XW-1:0]   dout;
  logic              dout_vld;
  logic              dout_last;
  logic              dout_buf_sel;
  logic              sync_out;
  logic [4:0]        fifo_level;
  logic              err_overflow;
  logic              err_underflow;

  int n_vec = 0;
  int n_err = 0;

  correction_applicator dut (
    .clk           (clk),
    .rst           (rst),
    .corr_vld      (corr_vld),
    .corr_din      (corr_din),
    .corr_last     (corr_last),
    .corr_buf_sel  (corr_buf_sel),
    .xeng_sync     (xeng_sync),
    .xeng_vld      (xeng_vld),
    .xeng_din      (xeng_din),
    .dout          (dout),
    .dout_vld      (dout_vld),
    .dout_last     (dout_last),
    .dout_buf_sel  (dout_buf_sel),
    .sync_out      (sync_out),
    .fifo_level    (fifo_level),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [8*CW-1:0] corr_lane(input int lane, input int val);
    logic [8*CW-1:0] v;
    v = '0;
    v[(7-lane)*CW +: CW] = CW'(val);
    return v;
  endfunction

  function automatic logic [8*XW-1:0] raw_lane(input int lane, input int val);
    logic [8*XW-1:0] v;
    v = '0;
    v[(7-lane)*XW +: XW] = XW'(val);
    return v;
  endfunction

  function automatic logic signed [XW-1:0] dlane(input int lane);
    return dout[(7-lane)*XW +: XW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    if (dout !== '0) begin $display("FAIL reset_dout got %h want 0", dout); n_err++; end n_vec++;
    if (dout_vld !== 1'b0) begin $display("FAIL reset_vld got %b want 0", dout_vld); n_err++; end n_vec++;
    if (dout_last !== 1'b0) begin $display("FAIL reset_last got %b want 0", dout_last); n_err++; end n_vec++;
    if (dout_buf_sel !== 1'b0) begin $display("FAIL reset_buf_sel got %b want 0", dout_buf_sel); n_err++; end n_vec++;
    if (sync_out !== 1'b0) begin $display("FAIL reset_sync got %b want 0", sync_out); n_err++; end n_vec++;
    if (fifo_level !== 5'd0) begin $display("FAIL reset_level got %0d want 0", fifo_level); n_err++; end n_vec++;
    if (err_overflow !== 1'b0) begin $display("FAIL reset_ovf got %b want 0", err_overflow); n_err++; end n_vec++;
    if (err_underflow !== 1'b0) begin $display("FAIL reset_udf got %b want 0", err_underflow); n_err++; end n_vec++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    corr_din = corr_lane(RE_XX, 10); corr_last = 1'b1; corr_buf_sel = 1'b0; corr_vld = 1'b1;
    step();
    corr_vld = 1'b0; corr_last = 1'b0;
    if (fifo_level !== 5'd1) begin $display("FAIL basic_level_push got %0d want 1", fifo_level); n_err++; end n_vec++;
    xeng_din = raw_lane(RE_XX, 5000); xeng_vld = 1'b1;
    step();
    xeng_vld = 1'b0;
    if (fifo_level !== 5'd0) begin $display("FAIL basic_level_pop got %0d want 0", fifo_level); n_err++; end n_vec++;
    if (dout_vld !== 1'b0) begin $display("FAIL basic_early_vld got %b want 0", dout_vld); n_err++; end n_vec++;
    step();
    if (dout_vld !== 1'b1) begin $display("FAIL basic_vld got %b want 1", dout_vld); n_err++; end n_vec++;
    if (dlane(RE_XX) !== -32'sd11464) begin $display("FAIL basic_re_xx got %0d want -11464", dlane(RE_XX)); n_err++; end n_vec++;
    if (dlane(RE_XY) !== -32'sd16384) begin $display("FAIL basic_re_xy got %0d want -16384", dlane(RE_XY)); n_err++; end n_vec++;
    if (dlane(IM_XX) !== 32'sd0) begin $display("FAIL basic_im_xx got %0d want 0", dlane(IM_XX)); n_err++; end n_vec++;
    if (dout_last !== 1'b1) begin $display("FAIL basic_last got %b want 1", dout_last); n_err++; end n_vec++;
    step();
    if (dout_vld !== 1'b0) begin $display("FAIL basic_vld_drop got %b want 0", dout_vld); n_err++; end n_vec++;
  endtask

  task automatic test_imag();
    corr_din = corr_lane(IM_XY, -3) | corr_lane(RE_YX, 5); corr_last = 1'b0; corr_buf_sel = 1'b1; corr_vld = 1'b1;
    step();
    corr_vld = 1'b0; corr_buf_sel = 1'b0;
    xeng_din = raw_lane(IM_XY, 100) | raw_lane(RE_XX, 1000); xeng_vld = 1'b1;
    step();
    xeng_vld = 1'b0;
    step();
    if (dlane(IM_XY) !== 32'sd124) begin $display("FAIL imag_im_xy got %0d want 124", dlane(IM_XY)); n_err++; end n_vec++;
    if (dlane(RE_XX) !== -32'sd15384) begin $display("FAIL imag_re_xx got %0d want -15384", dlane(RE_XX)); n_err++; end n_vec++;
    if (dlane(RE_YX) !== -32'sd16424) begin $display("FAIL imag_re_yx got %0d want -16424", dlane(RE_YX)); n_err++; end n_vec++;
    if (dlane(IM_YY) !== 32'sd0) begin $display("FAIL imag_im_yy got %0d want 0", dlane(IM_YY)); n_err++; end n_vec++;
    if (dout_buf_sel !== 1'b1) begin $display("FAIL imag_buf_sel got %b want 1", dout_buf_sel); n_err++; end n_vec++;
    if (dout_last !== 1'b0) begin $display("FAIL imag_last got %b want 0", dout_last); n_err++; end n_vec++;
  endtask

  task automatic test_overflow();
    logic signed [XW-1:0] e;
    int v;
    corr_vld = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      corr_din = corr_lane(RE_XX, k);
      step();
    end
    if (fifo_level !== 5'd16) begin $display("FAIL ovf_level_full got %0d want 16", fifo_level); n_err++; end n_vec++;
    if (err_overflow !== 1'b0) begin $display("FAIL ovf_flag_early got %b want 0", err_overflow); n_err++; end n_vec++;
    corr_din = corr_lane(RE_XX, 99);
    step();
    if (fifo_level !== 5'd16) begin $display("FAIL ovf_level_17th got %0d want 16", fifo_level); n_err++; end n_vec++;
    if (err_overflow !== 1'b1) begin $display("FAIL ovf_flag got %b want 1", err_overflow); n_err++; end n_vec++;
    corr_din = corr_lane(RE_XX, 100); xeng_din = '0; xeng_vld = 1'b1;
    step();
    corr_vld = 1'b0;
    if (fifo_level !== 5'd16) begin $display("FAIL ovf_level_pushpop got %0d want 16", fifo_level); n_err++; end n_vec++;
    if (err_underflow !== 1'b0) begin $display("FAIL ovf_udf_flag got %b want 0", err_underflow); n_err++; end n_vec++;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c == 16) xeng_vld = 1'b0;
      v = (c - 1 < 16) ? c : 100;
      e = -(v * 8) - 16384;
      if (dout_vld !== 1'b1) begin $display("FAIL drain_vld[%0d] got %b want 1", c - 1, dout_vld); n_err++; end n_vec++;
      if (dlane(RE_XX) !== e) begin $display("FAIL drain_re_xx[%0d] got %0d want %0d", c - 1, dlane(RE_XX), e); n_err++; end n_vec++;
    end
    if (fifo_level !== 5'd0) begin $display("FAIL drain_level got %0d want 0", fifo_level); n_err++; end n_vec++;
    if (err_underflow !== 1'b0) begin $display("FAIL drain_udf got %b want 0", err_underflow); n_err++; end n_vec++;
  endtask

  task automatic test_underflow();
    xeng_din = '0;
    for (int l = 0; l < 8; l++) xeng_din |= raw_lane(l, 77);
    xeng_vld = 1'b1;
    step();
    xeng_vld = 1'b0;
    if (err_underflow !== 1'b1) begin $display("FAIL udf_flag got %b want 1", err_underflow); n_err++; end n_vec++;
    step();
    if (dout_vld !== 1'b1) begin $display("FAIL udf_vld got %b want 1", dout_vld); n_err++; end n_vec++;
    for (int l = 0; l < 8; l++) begin
      if (dlane(l) !== 32'sd77) begin $display("FAIL udf_lane[%0d] got %0d want 77", l, dlane(l)); n_err++; end n_vec++;
    end
    if (dout_last !== 1'b0) begin $display("FAIL udf_last got %b want 0", dout_last); n_err++; end n_vec++;
    if (dout_buf_sel !== 1'b0) begin $display("FAIL udf_buf_sel got %b want 0", dout_buf_sel); n_err++; end n_vec++;
    if (fifo_level !== 5'd0) begin $display("FAIL udf_level got %0d want 0", fifo_level); n_err++; end n_vec++;
  endtask

  task automatic drive_b2b(input int i);
    corr_vld     = 1'b1;
    xeng_vld     = 1'b1;
    corr_din     = corr_lane(RE_XX, i) | corr_lane(IM_YY, -i);
    corr_buf_sel = i[0];
    corr_last    = 1'b0;
    xeng_din     = raw_lane(RE_XX, 100 * i) | raw_lane(IM_YY, i);
    xeng_sync    = (i == 5);
  endtask

  task automatic test_back_to_back();
    logic signed [XW-1:0] e;
    int p;
    do_reset();
    drive_b2b(0);
    for (int c = 0; c <= 32; c++) begin
      step();
      if (c + 1 < 32) drive_b2b(c + 1);
      else begin
        corr_vld = 1'b0; xeng_vld = 1'b0; xeng_sync = 1'b0; corr_buf_sel = 1'b0;
      end
      if (c >= 1) begin
        p = c - 1;
        if (dout_vld !== 1'b1) begin $display("FAIL b2b_vld[%0d] got %b want 1", p, dout_vld); n_err++; end n_vec++;
        e = 92 * p - 16384;
        if (dlane(RE_XX) !== e) begin $display("FAIL b2b_re_xx[%0d] got %0d want %0d", p, dlane(RE_XX), e); n_err++; end n_vec++;
        e = 9 * p;
        if (dlane(IM_YY) !== e) begin $display("FAIL b2b_im_yy[%0d] got %0d want %0d", p, dlane(IM_YY), e); n_err++; end n_vec++;
        if (dout_buf_sel !== p[0]) begin $display("FAIL b2b_buf_sel[%0d] got %b want %b", p, dout_buf_sel, p[0]); n_err++; end n_vec++;
        if (sync_out !== (p == 5)) begin $display("FAIL b2b_sync[%0d] got %b want %b", p, sync_out, (p == 5)); n_err++; end n_vec++;
      end
    end
    if (fifo_level !== 5'd0) begin $display("FAIL b2b_level got %0d want 0", fifo_level); n_err++; end n_vec++;
    if (err_underflow !== 1'b0) begin $display("FAIL b2b_udf got %b want 0", err_underflow); n_err++; end n_vec++;
    if (err_overflow !== 1'b0) begin $display("FAIL b2b_ovf got %b want 0", err_overflow); n_err++; end n_vec++;
  endtask

  task automatic test_flush();
    do_reset();
    corr_last = 1'b1; corr_buf_sel = 1'b1; corr_vld = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      corr_din = corr_lane(RE_XX, k);
      step();
    end
    corr_vld = 1'b0; corr_last = 1'b0; corr_buf_sel = 1'b0;
    if (fifo_level !== 5'd5) begin $display("FAIL flush_level_pre got %0d want 5", fifo_level); n_err++; end n_vec++;
    xeng_din = raw_lane(RE_XX, 1); xeng_vld = 1'b1; xeng_sync = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; xeng_vld = 1'b0; xeng_sync = 1'b0;
    if (dout !== '0) begin $display("FAIL flush_dout got %h want 0", dout); n_err++; end n_vec++;
    if (dout_vld !== 1'b0) begin $display("FAIL flush_vld got %b want 0", dout_vld); n_err++; end n_vec++;
    if (dout_last !== 1'b0) begin $display("FAIL flush_last got %b want 0", dout_last); n_err++; end n_vec++;
    if (dout_buf_sel !== 1'b0) begin $display("FAIL flush_buf_sel got %b want 0", dout_buf_sel); n_err++; end n_vec++;
    if (sync_out !== 1'b0) begin $display("FAIL flush_sync got %b want 0", sync_out); n_err++; end n_vec++;
    if (fifo_level !== 5'd0) begin $display("FAIL flush_level got %0d want 0", fifo_level); n_err++; end n_vec++;
    if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      $display("FAIL flush_err got ovf=%b udf=%b want 0/0", err_overflow, err_underflow); n_err++;
    end
    n_vec++;
    for (int c = 0; c < 3; c++) begin
      step();
      if (dout_vld !== 1'b0) begin $display("FAIL flush_late_vld[%0d] got %b want 0", c, dout_vld); n_err++; end n_vec++;
      if (sync_out !== 1'b0) begin $display("FAIL flush_late_sync[%0d] got %b want 0", c, sync_out); n_err++; end n_vec++;
    end
  endtask

  initial begin
    rst = 1'b1; corr_vld = 1'b0; corr_din = '0; corr_last = 1'b0; corr_buf_sel = 1'b0;
    xeng_sync = 1'b0; xeng_vld = 1'b0; xeng_din = '0;
    test_reset();
    test_basic();
    test_imag();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
